param_lfsr: RTL

PARAM_LFSR -- requirements
Module: param_lfsr

---
 rtl/param_lfsr.sv | 91 +++++++++
 1 files changed

// File: rtl/param_lfsr.sv
// Parameterised Fibonacci/Galois LFSR with a valid/ready output stream,
// run-time seed/tap load, all-zero lockup recovery, step counter and wrap flag.
module param_lfsr #(
   parameter int unsigned       WIDTH        = 8,
   parameter logic [WIDTH-1:0]  DEFAULT_SEED = WIDTH'(1),
   parameter logic [WIDTH-1:0]  DEFAULT_TAP  = WIDTH'('hB8)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_seed,
   input  logic [WIDTH-1:0] load_tap,
   input  logic             galois,
   input  logic             en,
   output logic [WIDTH-1:0] dout,
   output logic             dout_valid,
   input  logic             dout_ready,
   output logic             lockup,
   output logic [WIDTH-1:0] step_count,
   output logic             wrapped
);

   typedef enum logic {IDLE, RUN} fsm_t;

   fsm_t             fsm_q;
   logic [WIDTH-1:0] state_q;
   logic [WIDTH-1:0] tap_q;
   logic [WIDTH-1:0] seed_q;
   logic [WIDTH-1:0] step_q;
   logic             lockup_q;
   logic             wrapped_q;

   logic [WIDTH-1:0] fib_next;
   logic [WIDTH-1:0] gal_next;
   logic [WIDTH-1:0] adv_next;
   logic [WIDTH-1:0] wr_val;
   logic [WIDTH-1:0] new_state;
   logic             xfer;
   logic             wr_en;
   logic             wr_zero;

   // Next-state candidates; a load always wins over a concurrent advance.
   always_comb begin
      fib_next  = {state_q[WIDTH-2:0], ^(state_q & tap_q)};
      gal_next  = (state_q << 1) ^ (state_q[WIDTH-1] ? tap_q : '0);
      adv_next  = galois ? gal_next : fib_next;
      xfer      = (fsm_q == RUN) && dout_ready;
      wr_en     = load || xfer;
      wr_val    = load ? load_seed : adv_next;
      wr_zero   = (wr_val == '0);
      new_state = wr_zero ? DEFAULT_SEED : wr_val;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fsm_q     <= IDLE;
         state_q   <= DEFAULT_SEED;
         tap_q     <= DEFAULT_TAP;
         seed_q    <= DEFAULT_SEED;
         step_q    <= '0;
         lockup_q  <= 1'b0;
         wrapped_q <= 1'b0;
      end else begin
         unique case (fsm_q)
            IDLE:    if (en) fsm_q <= RUN;
            RUN:     if (!en && dout_ready) fsm_q <= IDLE;
            default: fsm_q <= IDLE;
         endcase

         lockup_q <= wr_en && wr_zero;
         if (wr_en) state_q <= new_state;

         if (load) begin
            tap_q     <= load_tap;
            seed_q    <= load_seed;
            step_q    <= '0;
            wrapped_q <= 1'b0;
         end else if (xfer) begin
            if (step_q != '1) step_q <= step_q + WIDTH'(1);
            if (new_state == seed_q) wrapped_q <= 1'b1;
         end
      end
   end

   assign dout       = state_q;
   assign dout_valid = (fsm_q == RUN);
   assign lockup     = lockup_q;
   assign step_count = step_q;
   assign wrapped    = wrapped_q;

endmodule
